// File: rtl/rf_pkg.sv
// Shared constants, index width helper and index type for the register file.
package rf_pkg;

   localparam int unsigned RF_WIDTH    = 64;
   localparam int unsigned RF_DEPTH    = 32;
   localparam int unsigned RF_ZERO_REG = 31;

   // Address width for a given depth; never narrower than one bit.
   function automatic int unsigned rf_aw(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   localparam int unsigned RF_AW = rf_aw(RF_DEPTH);

   typedef logic [RF_AW-1:0] reg_idx_t;

   // An index takes part in reads/writes/reserves only if it is in range and not the zero register.
   function automatic logic rf_idx_ok(input int unsigned idx, input int unsigned depth,
                                      input int unsigned zero_reg);
      return (idx < depth) && (idx != zero_reg);
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set by a reserve from issue, cleared by a writeback.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int unsigned DEPTH    = RF_DEPTH,
   parameter int unsigned ZERO_REG = RF_ZERO_REG,
   localparam int unsigned AW      = rf_aw(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [DEPTH-1:0] i_clr,
   input  logic             i_rsv_vld,
   input  logic [AW-1:0]    i_rsv_idx,
   output logic [DEPTH-1:0] o_busy
);

   logic [DEPTH-1:0] r_busy;
   logic [DEPTH-1:0] w_busy_d;
   logic             w_rsv_ok;

   assign w_rsv_ok = i_rsv_vld && rf_idx_ok(32'(i_rsv_idx), DEPTH, ZERO_REG);

   // Next busy state: a reserve in the same cycle as a write wins (it is a newer producer).
   always_comb begin
      w_busy_d = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         w_busy_d[k] = (w_rsv_ok && (i_rsv_idx == AW'(k))) || (r_busy[k] && !i_clr[k]);
      end
   end

   // Busy vector register with asynchronous clear.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_d;
      end
   end

   assign o_busy = r_busy;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with same-cycle write bypass and a busy scoreboard.
module regfile_mp_sb
   import rf_pkg::*;
#(
   parameter int unsigned WIDTH    = RF_WIDTH,
   parameter int unsigned DEPTH    = RF_DEPTH,
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned NUM_WR   = 2,
   parameter int unsigned ZERO_REG = RF_ZERO_REG,
   parameter bit          BYPASS   = 1'b1,
   localparam int unsigned AW      = rf_aw(DEPTH)
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [NUM_RD*AW-1:0]    i_ra,
   output logic [NUM_RD*WIDTH-1:0] o_bus_r,
   output logic [NUM_RD-1:0]       o_busy_r,
   input  logic [NUM_WR*AW-1:0]    i_rw,
   input  logic [NUM_WR*WIDTH-1:0] i_bus_w,
   input  logic [NUM_WR-1:0]       i_reg_wr,
   input  logic                    i_rsv_vld,
   input  logic [AW-1:0]           i_rsv_idx,
   output logic                    o_any_busy
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   logic [DEPTH-1:0] w_wr_en;
   logic [WIDTH-1:0] w_wr_data [DEPTH];
   logic [DEPTH-1:0] w_busy;

   // Per-register write select; ascending port scan lets the highest port win.
   always_comb begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
         w_wr_en[k]   = 1'b0;
         w_wr_data[k] = '0;
         for (int unsigned j = 0; j < NUM_WR; j++) begin
            if (i_reg_wr[j] && (i_rw[j*AW +: AW] == AW'(k)) && rf_idx_ok(k, DEPTH, ZERO_REG)) begin
               w_wr_en[k]   = 1'b1;
               w_wr_data[k] = i_bus_w[j*WIDTH +: WIDTH];
            end
         end
      end
   end

   // Storage array; the zero register is never enabled so it stays at reset value.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            r_mem[k] <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            if (w_wr_en[k]) begin
               r_mem[k] <= w_wr_data[k];
            end
         end
      end
   end

   rf_scoreboard #(
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_clr     (w_wr_en),
      .i_rsv_vld (i_rsv_vld),
      .i_rsv_idx (i_rsv_idx),
      .o_busy    (w_busy)
   );

   // Read ports: stored value, overridden by same-cycle write data; busy is never bypassed.
   always_comb begin
      o_bus_r  = '0;
      o_busy_r = '0;
      for (int unsigned i = 0; i < NUM_RD; i++) begin
         if (rf_idx_ok(32'(i_ra[i*AW +: AW]), DEPTH, ZERO_REG)) begin
            o_bus_r[i*WIDTH +: WIDTH] = r_mem[i_ra[i*AW +: AW]];
            o_busy_r[i]               = w_busy[i_ra[i*AW +: AW]];
            if (BYPASS) begin
               for (int unsigned j = 0; j < NUM_WR; j++) begin
                  if (i_reg_wr[j] && (i_rw[j*AW +: AW] == i_ra[i*AW +: AW])) begin
                     o_bus_r[i*WIDTH +: WIDTH] = i_bus_w[j*WIDTH +: WIDTH];
                  end
               end
            end
         end
      end
   end

   assign o_any_busy = |w_busy;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: directed scenarios plus randomized traffic
// compared against an array-based reference model.
module tb_regfile_mp_sb;

   localparam int unsigned W  = 64;
   localparam int unsigned D  = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned ZR = 31;

   logic            clk;
   logic            rst_n;
   logic [2*AW-1:0] i_ra;
   logic [2*W-1:0]  o_bus_r;
   logic [1:0]      o_busy_r;
   logic [2*AW-1:0] i_rw;
   logic [2*W-1:0]  i_bus_w;
   logic [1:0]      we;
   logic            rsv_vld;
   logic [AW-1:0]   rsv_idx;
   logic            o_any_busy;

   logic [AW-1:0] ra [2];
   logic [AW-1:0] rw [2];
   logic [W-1:0]  bw [2];

   assign i_ra    = {ra[1], ra[0]};
   assign i_rw    = {rw[1], rw[0]};
   assign i_bus_w = {bw[1], bw[0]};

   // Reference model state
   logic [W-1:0] m_mem  [D];
   bit           m_busy [D];

   int n_pass  = 0;
   int n_total = 0;

   regfile_mp_sb #(
      .WIDTH    (W),
      .DEPTH    (D),
      .NUM_RD   (2),
      .NUM_WR   (2),
      .ZERO_REG (ZR),
      .BYPASS   (1'b1)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_ra       (i_ra),
      .o_bus_r    (o_bus_r),
      .o_busy_r   (o_busy_r),
      .i_rw       (i_rw),
      .i_bus_w    (i_bus_w),
      .i_reg_wr   (we),
      .i_rsv_vld  (rsv_vld),
      .i_rsv_idx  (rsv_idx),
      .o_any_busy (o_any_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] exp_data(input logic [AW-1:0] a);
      logic [W-1:0] d;
      if (a == ZR) return '0;
      d = m_mem[a];
      for (int j = 0; j < 2; j++) begin
         if (we[j] && rw[j] == a) d = bw[j];
      end
      return d;
   endfunction

   function automatic logic exp_busy(input logic [AW-1:0] a);
      return (a == ZR) ? 1'b0 : m_busy[a];
   endfunction

   function automatic logic exp_any();
      logic any = 1'b0;
      for (int k = 0; k < D; k++) any |= m_busy[k];
      return any;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < D; k++) begin
         m_mem[k]  = '0;
         m_busy[k] = 0;
      end
   endtask

   // Apply what a rising edge does to the model, using the inputs present at the edge.
   task automatic model_step();
      if (!rst_n) begin
         model_clear();
      end else begin
         for (int j = 0; j < 2; j++) begin
            if (we[j] && rw[j] != ZR) begin
               m_mem[rw[j]]  = bw[j];
               m_busy[rw[j]] = 0;
            end
         end
         if (rsv_vld && rsv_idx != ZR) m_busy[rsv_idx] = 1;
      end
   endtask

   task automatic idle();
      ra[0] = '0; ra[1] = '0; rw[0] = '0; rw[1] = '0;
      bw[0] = '0; bw[1] = '0; we = '0; rsv_vld = 1'b0; rsv_idx = '0;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      model_clear();
      repeat (3) @(negedge clk);
      #1;
      n_total++;
      if (o_any_busy !== 1'b0) $display("FAIL reset_any_in_reset: got %b want 0", o_any_busy);
      else n_pass++;
      rst_n = 1'b1;
      for (int a = 0; a < D; a++) begin
         ra[0] = AW'(a);
         ra[1] = AW'(D - 1 - a);
         #1;
         n_total++;
         if (o_bus_r !== '0 || o_busy_r !== 2'b00)
            $display("FAIL reset_read a=%0d: got %h busy %b want 0 busy 00", a, o_bus_r, o_busy_r);
         else n_pass++;
      end
      n_total++;
      if (o_any_busy !== 1'b0) $display("FAIL reset_any: got %b want 0", o_any_busy);
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_basic_write();
      idle();
      we[0] = 1'b1; rw[0] = 5; bw[0] = 64'hDEAD_BEEF;
      cycle();
      idle();
      ra[0] = 5;
      #1;
      n_total++;
      if (o_bus_r[W-1:0] !== 64'hDEAD_BEEF)
         $display("FAIL basic_write: got %h want %h", o_bus_r[W-1:0], 64'hDEAD_BEEF);
      else n_pass++;
   endtask

   task automatic test_zero_reg();
      idle();
      we[0] = 1'b1; rw[0] = ZR; bw[0] = 64'hFFFF; ra[1] = ZR;
      #1;
      n_total++;
      if (o_bus_r[W +: W] !== '0) $display("FAIL zero_reg_bypass: got %h want 0", o_bus_r[W +: W]);
      else n_pass++;
      cycle();
      idle();
      ra[0] = ZR;
      #1;
      n_total++;
      if (o_bus_r[W-1:0] !== '0 || o_busy_r[0] !== 1'b0)
         $display("FAIL zero_reg: got %h busy %b want 0 busy 0", o_bus_r[W-1:0], o_busy_r[0]);
      else n_pass++;
   endtask

   task automatic test_bypass_conflict();
      idle();
      we = 2'b11; rw[0] = 7; rw[1] = 7; bw[0] = 64'd1; bw[1] = 64'd2; ra[1] = 7;
      #1;
      n_total++;
      if (o_bus_r[W +: W] !== 64'd2) $display("FAIL bypass_conflict: got %h want 2", o_bus_r[W +: W]);
      else n_pass++;
      cycle();
      idle();
      ra[1] = 7;
      #1;
      n_total++;
      if (o_bus_r[W +: W] !== 64'd2) $display("FAIL conflict_stored: got %h want 2", o_bus_r[W +: W]);
      else n_pass++;
   endtask

   task automatic test_scoreboard();
      idle();
      rsv_vld = 1'b1; rsv_idx = 9;
      cycle();
      idle();
      ra[0] = 9;
      #1;
      n_total++;
      if (o_busy_r[0] !== 1'b1 || o_any_busy !== 1'b1)
         $display("FAIL sb_reserve: got busy %b any %b want 1 1", o_busy_r[0], o_any_busy);
      else n_pass++;
      we[0] = 1'b1; rw[0] = 9; bw[0] = 64'd3;
      #1;
      n_total++;
      if (o_busy_r[0] !== 1'b1 || o_bus_r[W-1:0] !== 64'd3)
         $display("FAIL sb_no_busy_bypass: got busy %b data %h want 1 3", o_busy_r[0], o_bus_r[W-1:0]);
      else n_pass++;
      cycle();
      idle();
      ra[0] = 9;
      #1;
      n_total++;
      if (o_busy_r[0] !== 1'b0 || o_bus_r[W-1:0] !== 64'd3 || o_any_busy !== 1'b0)
         $display("FAIL sb_clear: got busy %b data %h any %b want 0 3 0",
                  o_busy_r[0], o_bus_r[W-1:0], o_any_busy);
      else n_pass++;
      rsv_vld = 1'b1; rsv_idx = 9; we[0] = 1'b1; rw[0] = 9; bw[0] = 64'd4;
      cycle();
      idle();
      ra[0] = 9;
      #1;
      n_total++;
      if (o_busy_r[0] !== 1'b1 || o_bus_r[W-1:0] !== 64'd4)
         $display("FAIL sb_rsv_and_write: got busy %b data %h want 1 4", o_busy_r[0], o_bus_r[W-1:0]);
      else n_pass++;
      rsv_vld = 1'b1; rsv_idx = ZR;
      cycle();
      idle();
      ra[1] = ZR;
      #1;
      n_total++;
      if (o_busy_r[1] !== 1'b0) $display("FAIL sb_rsv_zero: got busy %b want 0", o_busy_r[1]);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      idle();
      we[0] = 1'b1; rw[0] = 4; bw[0] = 64'd10;
      cycle();
      idle();
      rsv_vld = 1'b1; rsv_idx = 4;
      cycle();
      idle();
      ra[0] = 4;
      #1;
      n_total++;
      if (o_bus_r[W-1:0] !== 64'd10 || o_busy_r[0] !== 1'b1)
         $display("FAIL async_setup: got data %h busy %b want a 1", o_bus_r[W-1:0], o_busy_r[0]);
      else n_pass++;
      #1 rst_n = 1'b0;
      model_clear();
      #1;
      n_total++;
      if (o_bus_r[W-1:0] !== '0 || o_busy_r[0] !== 1'b0 || o_any_busy !== 1'b0)
         $display("FAIL async_reset: got data %h busy %b any %b want 0 0 0",
                  o_bus_r[W-1:0], o_busy_r[0], o_any_busy);
      else n_pass++;
      we[0] = 1'b1; rw[0] = 4; bw[0] = 64'd55; rsv_vld = 1'b1; rsv_idx = 4;
      cycle();
      idle();
      ra[0] = 4;
      rst_n = 1'b1;
      #1;
      n_total++;
      if (o_bus_r[W-1:0] !== '0 || o_busy_r[0] !== 1'b0)
         $display("FAIL reset_override: got data %h busy %b want 0 0", o_bus_r[W-1:0], o_busy_r[0]);
      else n_pass++;
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         idle();
         for (int j = 0; j < 2; j++) begin
            rw[j] = AW'($urandom_range(0, D - 1));
            bw[j] = {$urandom, $urandom};
            we[j] = ($urandom_range(0, 3) != 0);
         end
         if ($urandom_range(0, 3) == 0) rw[1] = rw[0];
         for (int i = 0; i < 2; i++) begin
            case ($urandom_range(0, 2))
               0:       ra[i] = rw[0];
               1:       ra[i] = rw[1];
               default: ra[i] = AW'($urandom_range(0, D - 1));
            endcase
         end
         rsv_vld = ($urandom_range(0, 2) == 0);
         rsv_idx = ($urandom_range(0, 1) == 0) ? rw[$urandom_range(0, 1)]
                                               : AW'($urandom_range(0, D - 1));
         #1;
         for (int i = 0; i < 2; i++) begin
            n_total++;
            if (o_bus_r[i*W +: W] !== exp_data(ra[i]))
               $display("FAIL rand_data n=%0d port%0d ra=%0d: got %h want %h",
                        n, i, ra[i], o_bus_r[i*W +: W], exp_data(ra[i]));
            else n_pass++;
            n_total++;
            if (o_busy_r[i] !== exp_busy(ra[i]))
               $display("FAIL rand_busy n=%0d port%0d ra=%0d: got %b want %b",
                        n, i, ra[i], o_busy_r[i], exp_busy(ra[i]));
            else n_pass++;
         end
         n_total++;
         if (o_any_busy !== exp_any())
            $display("FAIL rand_any n=%0d: got %b want %b", n, o_any_busy, exp_any());
         else n_pass++;
         cycle();
      end
   endtask

   initial begin
      test_reset();
      test_basic_write();
      test_zero_reg();
      test_bypass_conflict();
      test_scoreboard();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
